// File: rtl/awg_pkg.sv
// Shared definitions for the DDS waveform generator: waveform encodings,
// sample pipeline depth and the offset-binary midscale helper.
package awg_pkg;

    typedef enum logic [1:0] {
        WAVE_SINE   = 2'd0,
        WAVE_SQUARE = 2'd1,
        WAVE_TRI    = 2'd2,
        WAVE_SAW    = 2'd3
    } wave_mode_e;

    localparam int DDS_LAT = 4;

    function automatic logic [31:0] midscale(input int unsigned dac_w);
        return 32'(1) << (dac_w - 1);
    endfunction

endpackage

// File: rtl/dds_sin_rom.sv
// Registered quarter-wave sine ROM: mirrors the index in the second half of each
// half-period and negates in the second half, giving a signed two's-complement sample.
module dds_sin_rom #(
    parameter int LUT_AW = 10,
    parameter int DAC_W  = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LUT_AW-1:0] phase_i,
    output logic [DAC_W-1:0]  sample_o
);
    localparam int  QN = 2 ** (LUT_AW - 2);
    localparam int  M  = 2 ** (DAC_W - 1) - 1;
    localparam real PI = 3.14159265358979323846;

    // Table is built at elaboration; the Taylor series is exact to well below one LSB
    // over the first quadrant.
    function automatic logic [DAC_W-2:0] sin_entry(input int k);
        real x;
        real term;
        real s;
        x    = 2.0 * PI * (real'(k) + 0.5) / real'(QN * 4);
        term = x;
        s    = x;
        for (int n = 1; n < 10; n++) begin
            term = -term * x * x / real'((2 * n) * (2 * n + 1));
            s    = s + term;
        end
        return (DAC_W-1)'($rtoi(real'(M) * s + 0.5));
    endfunction

    logic [DAC_W-2:0] rom [QN];

    for (genvar k = 0; k < QN; k++) begin : g_rom
        localparam logic [DAC_W-2:0] ENTRY = sin_entry(k);
        assign rom[k] = ENTRY;
    end

    logic [LUT_AW-3:0] idx;
    logic [DAC_W-1:0]  mag;
    logic [DAC_W-1:0]  sample_q;
    logic [DAC_W-1:0]  sample_d;

    assign idx      = phase_i[LUT_AW-2] ? ~phase_i[LUT_AW-3:0] : phase_i[LUT_AW-3:0];
    assign mag      = {1'b0, rom[idx]};
    assign sample_d = phase_i[LUT_AW-1] ? -mag : mag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_q <= '0;
        end else begin
            sample_q <= sample_d;
        end
    end

    assign sample_o = sample_q;

endmodule

// File: rtl/dds_wave_gen.sv
// DDS waveform generator: phase accumulator, shadowed configuration applied at the
// period wrap, and a fixed four-stage sample pipeline feeding an offset-binary DAC.
module dds_wave_gen
    import awg_pkg::*;
#(
    parameter int ACC_W  = 32,
    parameter int LUT_AW = 10,
    parameter int DAC_W  = 14,
    parameter int AMP_W  = 8,
    parameter int PH_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_load,
    input  logic [ACC_W-1:0] ftw,
    input  logic [AMP_W-1:0] amp,
    input  logic [PH_W-1:0]  phase_ofs,
    input  logic [1:0]       wave_mode,
    output logic             cfg_busy,
    output logic [DAC_W-1:0] dac_out,
    output logic             dac_valid,
    output logic             cycle_sync
);
    localparam logic [DAC_W-1:0] MID   = DAC_W'(midscale(DAC_W));
    localparam logic [DAC_W-1:0] POS_M = ~MID;
    localparam logic [DAC_W-1:0] NEG_M = MID | DAC_W'(1);

    // Offset-binary ramp to signed sample; the most negative code is clipped to -M.
    function automatic logic [DAC_W-1:0] ramp_to_sample(input logic [DAC_W-1:0] r);
        logic [DAC_W-1:0] s;
        s = r ^ MID;
        return (s == MID) ? NEG_M : s;
    endfunction

    logic [ACC_W-1:0] acc_q, acc_d;
    logic             wrap_q, wrap_d;
    logic [ACC_W:0]   acc_sum;
    logic             carry;
    logic             apply;

    logic [ACC_W-1:0] ftw_act_q, ftw_shd_q;
    logic [AMP_W-1:0] amp_act_q, amp_shd_q;
    logic [PH_W-1:0]  ph_act_q, ph_shd_q;
    wave_mode_e       mode_act_q, mode_shd_q;
    logic             busy_q;

    assign acc_sum = {1'b0, acc_q} + {1'b0, ftw_act_q};
    assign carry   = acc_sum[ACC_W];
    assign acc_d   = en ? acc_sum[ACC_W-1:0] : acc_q;
    assign wrap_d  = en & carry;
    assign apply   = busy_q & (~en | (ftw_act_q == '0) | carry);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q      <= '0;
            wrap_q     <= 1'b0;
            ftw_act_q  <= '0;
            amp_act_q  <= '0;
            ph_act_q   <= '0;
            mode_act_q <= WAVE_SINE;
            ftw_shd_q  <= '0;
            amp_shd_q  <= '0;
            ph_shd_q   <= '0;
            mode_shd_q <= WAVE_SINE;
            busy_q     <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            wrap_q <= wrap_d;
            // A load can only be accepted while idle, so it never collides with an apply.
            if (apply) begin
                ftw_act_q  <= ftw_shd_q;
                amp_act_q  <= amp_shd_q;
                ph_act_q   <= ph_shd_q;
                mode_act_q <= mode_shd_q;
                busy_q     <= 1'b0;
            end else if (cfg_load && !busy_q) begin
                ftw_shd_q  <= ftw;
                amp_shd_q  <= amp;
                ph_shd_q   <= phase_ofs;
                mode_shd_q <= wave_mode_e'(wave_mode);
                busy_q     <= 1'b1;
            end
        end
    end

    logic [DDS_LAT-1:0]     vld_q, sync_q;
    logic [LUT_AW-1:0]      p1_q, p1_d;
    wave_mode_e             mode1_q, mode2_q;
    logic [AMP_W-1:0]       amp1_q, amp2_q;
    logic [LUT_AW-2:0]      fold;
    logic [DAC_W-1:0]       tri_r, saw_r;
    logic [DAC_W-1:0]       alt2_q, alt2_d;
    logic [DAC_W-1:0]       sin2;
    logic [DAC_W-1:0]       s3;
    logic signed [DAC_W+AMP_W:0] prod;
    logic [DAC_W-1:0]       y3_q, y3_d;
    logic [DAC_W-1:0]       dac_q, dac_d;

    assign p1_d  = acc_q[ACC_W-1 -: LUT_AW] + (LUT_AW'(ph_act_q) << (LUT_AW - PH_W));
    assign fold  = p1_q[LUT_AW-1] ? ~p1_q[LUT_AW-2:0] : p1_q[LUT_AW-2:0];
    assign tri_r = DAC_W'(fold) << (DAC_W - LUT_AW + 1);
    assign saw_r = DAC_W'(p1_q) << (DAC_W - LUT_AW);

    dds_sin_rom #(
        .LUT_AW (LUT_AW),
        .DAC_W  (DAC_W)
    ) u_sin_rom (
        .clk      (clk),
        .rst      (rst),
        .phase_i  (p1_q),
        .sample_o (sin2)
    );

    always_comb begin
        alt2_d = '0;
        case (mode1_q)
            WAVE_SQUARE: alt2_d = p1_q[LUT_AW-1] ? NEG_M : POS_M;
            WAVE_TRI:    alt2_d = ramp_to_sample(tri_r);
            WAVE_SAW:    alt2_d = ramp_to_sample(saw_r);
            default:     alt2_d = '0;
        endcase
    end

    assign s3    = (mode2_q == WAVE_SINE) ? sin2 : alt2_q;
    assign prod  = $signed({{(AMP_W+1){s3[DAC_W-1]}}, s3}) * $signed({{(DAC_W+1){1'b0}}, amp2_q});
    assign y3_d  = DAC_W'(prod >>> AMP_W);
    assign dac_d = vld_q[DDS_LAT-2] ? (y3_q + MID) : MID;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q   <= '0;
            sync_q  <= '0;
            p1_q    <= '0;
            mode1_q <= WAVE_SINE;
            amp1_q  <= '0;
            mode2_q <= WAVE_SINE;
            amp2_q  <= '0;
            alt2_q  <= '0;
            y3_q    <= '0;
            dac_q   <= MID;
        end else begin
            vld_q   <= {vld_q[DDS_LAT-2:0], en};
            sync_q  <= {sync_q[DDS_LAT-2:0], wrap_q & en};
            p1_q    <= p1_d;
            mode1_q <= mode_act_q;
            amp1_q  <= amp_act_q;
            mode2_q <= mode1_q;
            amp2_q  <= amp1_q;
            alt2_q  <= alt2_d;
            y3_q    <= y3_d;
            dac_q   <= dac_d;
        end
    end

    assign cfg_busy   = busy_q;
    assign dac_out    = dac_q;
    assign dac_valid  = vld_q[DDS_LAT-1];
    assign cycle_sync = sync_q[DDS_LAT-1];

endmodule
